// File: rtl/tpm_fifo_pkg.sv
// rtl/tpm_fifo_pkg.sv - shared types and constants for the TPM FIFO register block
package tpm_fifo_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READY,
    ST_RECEPTION,
    ST_EXECUTION,
    ST_COMPLETION
  } tpm_state_e;

  localparam logic [11:0] OFF_STS      = 12'h018;
  localparam logic [11:0] OFF_BURST_LO = 12'h019;
  localparam logic [11:0] OFF_BURST_HI = 12'h01A;
  localparam logic [11:0] OFF_FIFO     = 12'h024;

  localparam int STS_VALID     = 7;
  localparam int STS_CMD_READY = 6;
  localparam int STS_GO        = 5;
  localparam int STS_AVAIL     = 4;
  localparam int STS_EXPECT    = 3;
  localparam int STS_RETRY     = 1;

  // Command header: tag(2) then 32-bit big-endian total size
  localparam int HDR_LEN = 6;
  localparam int SIZE_B0 = 2;
  localparam int SIZE_B1 = 3;
  localparam int SIZE_B2 = 4;
  localparam int SIZE_B3 = 5;

endpackage

// File: rtl/tpm_byte_buffer.sv
// rtl/tpm_byte_buffer.sv - DEPTH x 8 linear byte buffer with non-wrapping pointers
module tpm_byte_buffer #(
  parameter int DEPTH = 64,
  parameter int PW    = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clear_i,
  input  logic          wr_en_i,
  input  logic [7:0]    wr_data_i,
  input  logic          rd_en_i,
  input  logic          rewind_i,
  output logic [7:0]    rd_data_o,
  output logic [PW-1:0] wr_ptr_o,
  output logic [PW-1:0] rd_ptr_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic          full;

  assign full = (wr_ptr_q == DEPTH_P);

  always_ff @(posedge clk_i) begin
    if (wr_en_i && !full && !clear_i) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end
  end

  // Reads never pass the write pointer, so the read side cannot overrun
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en_i && !full) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (rewind_i) begin
        rd_ptr_q <= '0;
      end else if (rd_en_i && (rd_ptr_q < wr_ptr_q)) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];
  assign wr_ptr_o  = wr_ptr_q;
  assign rd_ptr_o  = rd_ptr_q;

endmodule

// File: rtl/tpm_fifo_regs.sv
// rtl/tpm_fifo_regs.sv - multi-locality TIS STS/DATA_FIFO block with command and response buffers
module tpm_fifo_regs
  import tpm_fifo_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int NUM_LOC = 5,
  parameter int BURST_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [15:0]        addr_i,
  input  logic [7:0]         data_i,
  input  logic               data_wr_i,
  input  logic               data_rd_i,
  output logic [7:0]         data_o,
  output logic               data_valid_o,
  input  logic [2:0]         active_loc_i,
  output logic [7:0]         cmd_data_o,
  output logic               cmd_valid_o,
  input  logic               cmd_ready_i,
  input  logic [7:0]         rsp_data_i,
  input  logic               rsp_valid_i,
  output logic               rsp_ready_o,
  input  logic               rsp_done_i,
  output logic               cmd_go_o,
  output logic [BURST_W-1:0] burst_count_o,
  output logic               data_avail_o,
  output logic               expect_o,
  output logic               command_ready_o
);

  localparam int PW = $clog2(DEPTH) + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  tpm_state_e    state_q;
  logic          cmd_go_q;
  logic [7:0]    data_q;
  logic          data_valid_q;
  logic [31:0]   cmd_size_q;

  logic [PW-1:0] rx_count, cmd_rd_ptr, rsp_wr_ptr, rsp_rd_ptr;
  logic [7:0]    cmd_byte, rsp_byte;
  logic [11:0]   offset;
  logic          acc_ok, wr_acc, rd_acc, sts_wr, fifo_wr;
  logic          cr_take, go_take, retry_take;
  logic          cmd_wr_en, cmd_rd_en, rsp_wr_en, rsp_rd_en;
  logic          expect_w, avail_w;
  logic [BURST_W-1:0] burst_w;
  logic [15:0]   burst16;
  logic [7:0]    sts_byte, rd_val;

  assign offset  = addr_i[11:0];
  assign acc_ok  = (addr_i[15:12] == {1'b0, active_loc_i}) && (int'(active_loc_i) < NUM_LOC);
  assign wr_acc  = data_wr_i & acc_ok;
  // A colliding write wins; the read is answered with 8'hFF
  assign rd_acc  = data_rd_i & ~data_wr_i & acc_ok;
  assign sts_wr  = wr_acc && (offset == OFF_STS);
  assign fifo_wr = wr_acc && (offset == OFF_FIFO);

  assign cr_take    = sts_wr && data_i[STS_CMD_READY] && (state_q != ST_EXECUTION);
  assign go_take    = sts_wr && !cr_take && data_i[STS_GO] && (state_q == ST_RECEPTION) && !expect_w;
  assign retry_take = sts_wr && !cr_take && data_i[STS_RETRY] && (state_q == ST_COMPLETION);

  assign expect_w = (state_q == ST_RECEPTION) && (rx_count != DEPTH_P) &&
                    ((rx_count < PW'(HDR_LEN)) || (32'(rx_count) < cmd_size_q));
  assign avail_w  = (state_q == ST_COMPLETION) && (rsp_rd_ptr < rsp_wr_ptr);

  assign cmd_wr_en   = fifo_wr && ((state_q == ST_READY) || (state_q == ST_RECEPTION));
  assign cmd_valid_o = (state_q == ST_EXECUTION) && (cmd_rd_ptr < rx_count);
  assign cmd_rd_en   = cmd_valid_o & cmd_ready_i;
  assign rsp_ready_o = (state_q == ST_EXECUTION) && (rsp_wr_ptr < DEPTH_P);
  assign rsp_wr_en   = rsp_valid_i & rsp_ready_o;
  assign rsp_rd_en   = rd_acc && (offset == OFF_FIFO) && avail_w;

  tpm_byte_buffer #(.DEPTH(DEPTH), .PW(PW)) u_cmd_buf (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (cr_take),
    .wr_en_i   (cmd_wr_en),
    .wr_data_i (data_i),
    .rd_en_i   (cmd_rd_en),
    .rewind_i  (1'b0),
    .rd_data_o (cmd_byte),
    .wr_ptr_o  (rx_count),
    .rd_ptr_o  (cmd_rd_ptr)
  );

  tpm_byte_buffer #(.DEPTH(DEPTH), .PW(PW)) u_rsp_buf (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (cr_take),
    .wr_en_i   (rsp_wr_en),
    .wr_data_i (rsp_data_i),
    .rd_en_i   (rsp_rd_en),
    .rewind_i  (retry_take),
    .rd_data_o (rsp_byte),
    .wr_ptr_o  (rsp_wr_ptr),
    .rd_ptr_o  (rsp_rd_ptr)
  );

  always_comb begin
    burst_w = '0;
    case (state_q)
      ST_READY, ST_RECEPTION: burst_w = BURST_W'(DEPTH_P - rx_count);
      ST_COMPLETION:          burst_w = BURST_W'(rsp_wr_ptr - rsp_rd_ptr);
      default:                burst_w = '0;
    endcase
  end

  always_comb begin
    burst16 = '0;
    for (int i = 0; i < 16 && i < BURST_W; i++) begin
      burst16[i] = burst_w[i];
    end
  end

  always_comb begin
    sts_byte                = '0;
    sts_byte[STS_VALID]     = (state_q != ST_IDLE);
    sts_byte[STS_CMD_READY] = (state_q == ST_READY);
    sts_byte[STS_AVAIL]     = avail_w;
    sts_byte[STS_EXPECT]    = expect_w;
  end

  always_comb begin
    rd_val = 8'hFF;
    if (rd_acc) begin
      case (offset)
        OFF_STS:      rd_val = sts_byte;
        OFF_BURST_LO: rd_val = burst16[7:0];
        OFF_BURST_HI: rd_val = burst16[15:8];
        OFF_FIFO:     rd_val = avail_w ? rsp_byte : 8'hFF;
        default:      rd_val = 8'hFF;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      cmd_go_q     <= 1'b0;
      data_q       <= 8'hFF;
      data_valid_q <= 1'b0;
      cmd_size_q   <= '0;
    end else begin
      cmd_go_q     <= go_take;
      data_valid_q <= data_rd_i;
      if (data_rd_i) begin
        data_q <= rd_val;
      end
      if (cr_take) begin
        state_q    <= ST_READY;
        cmd_size_q <= '0;
      end else begin
        case (state_q)
          ST_READY: begin
            if (fifo_wr) state_q <= ST_RECEPTION;
          end
          ST_RECEPTION: begin
            // Header bytes arrive in order, so shifting assembles the big-endian size
            if (cmd_wr_en && (rx_count >= PW'(SIZE_B0)) && (rx_count <= PW'(SIZE_B3))) begin
              cmd_size_q <= {cmd_size_q[23:0], data_i};
            end
            if (go_take) state_q <= ST_EXECUTION;
          end
          ST_EXECUTION: begin
            if (rsp_done_i) state_q <= ST_COMPLETION;
          end
          default: ;
        endcase
      end
    end
  end

  assign data_o          = data_q;
  assign data_valid_o    = data_valid_q;
  assign cmd_go_o        = cmd_go_q;
  assign cmd_data_o      = cmd_valid_o ? cmd_byte : 8'h00;
  assign burst_count_o   = burst_w;
  assign data_avail_o    = avail_w;
  assign expect_o        = expect_w;
  assign command_ready_o = (state_q == ST_READY);

endmodule

// File: tb/tb_tpm_fifo_regs.sv
// tb/tb_tpm_fifo_regs.sv - randomized scoreboard bench for tpm_fifo_regs
module tb_tpm_fifo_regs;

  localparam int DEPTH   = 64;
  localparam int NUM_LOC = 5;
  localparam int BURST_W = 16;
  localparam int S_IDLE = 0, S_READY = 1, S_RX = 2, S_EXEC = 3, S_COMPL = 4;

  logic clk = 1'b0;
  logic rst_i;
  logic [15:0] addr_i;
  logic [7:0] data_i, data_o, cmd_data_o, rsp_data_i;
  logic data_wr_i, data_rd_i, data_valid_o;
  logic [2:0] active_loc_i;
  logic cmd_valid_o, cmd_ready_i, rsp_valid_i, rsp_ready_o, rsp_done_i, cmd_go_o;
  logic [BURST_W-1:0] burst_count_o;
  logic data_avail_o, expect_o, command_ready_o;

  always #5 clk = ~clk;

  tpm_fifo_regs #(.DEPTH(DEPTH), .NUM_LOC(NUM_LOC), .BURST_W(BURST_W)) dut (
    .clk_i(clk), .rst_i(rst_i), .addr_i(addr_i), .data_i(data_i),
    .data_wr_i(data_wr_i), .data_rd_i(data_rd_i), .data_o(data_o),
    .data_valid_o(data_valid_o), .active_loc_i(active_loc_i),
    .cmd_data_o(cmd_data_o), .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i),
    .rsp_data_i(rsp_data_i), .rsp_valid_i(rsp_valid_i), .rsp_ready_o(rsp_ready_o),
    .rsp_done_i(rsp_done_i), .cmd_go_o(cmd_go_o), .burst_count_o(burst_count_o),
    .data_avail_o(data_avail_o), .expect_o(expect_o), .command_ready_o(command_ready_o)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] rd_exp[$];
  logic [7:0] cmd_exp[$];
  logic rd_seen = 1'b0;

  // Reference model: transaction-level view of the TIS protocol
  int m_st;
  logic [7:0] m_cmd[$];
  logic [7:0] m_rsp[$];
  int m_rd;
  longint m_size;
  logic m_go;
  int loc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void m_reset();
    m_st = S_IDLE;
    m_cmd.delete();
    m_rsp.delete();
    m_rd = 0;
    m_size = 0;
    m_go = 1'b0;
  endfunction

  function automatic logic m_expect();
    return (m_st == S_RX) && (m_cmd.size() != DEPTH) &&
           ((m_cmd.size() < 6) || (longint'(m_cmd.size()) < m_size));
  endfunction

  function automatic logic m_avail();
    return (m_st == S_COMPL) && (m_rd < m_rsp.size());
  endfunction

  function automatic int m_burst();
    if (m_st == S_READY || m_st == S_RX) return DEPTH - m_cmd.size();
    if (m_st == S_COMPL) return m_rsp.size() - m_rd;
    return 0;
  endfunction

  function automatic logic m_ok(input logic [15:0] a);
    return (int'(a[15:12]) == int'(active_loc_i)) && (int'(active_loc_i) < NUM_LOC);
  endfunction

  function automatic void m_write(input logic [15:0] a, input logic [7:0] d);
    m_go = 1'b0;
    if (!m_ok(a)) return;
    if (a[11:0] == 12'h018) begin
      if (d[6] && m_st != S_EXEC) begin
        m_cmd.delete();
        m_rsp.delete();
        m_rd = 0;
        m_size = 0;
        m_st = S_READY;
      end else begin
        if (d[5] && m_st == S_RX && !m_expect()) begin
          m_go = 1'b1;
          m_st = S_EXEC;
          foreach (m_cmd[i]) cmd_exp.push_back(m_cmd[i]);
        end
        if (d[1] && m_st == S_COMPL) m_rd = 0;
      end
    end else if (a[11:0] == 12'h024 && (m_st == S_READY || m_st == S_RX) && m_cmd.size() < DEPTH) begin
      if (m_cmd.size() >= 2 && m_cmd.size() <= 5) m_size = m_size * 256 + longint'(d);
      m_cmd.push_back(d);
      m_st = S_RX;
    end
  endfunction

  function automatic logic [7:0] m_read(input logic [15:0] a);
    logic [15:0] b;
    b = 16'(m_burst());
    if (!m_ok(a)) return 8'hFF;
    case (a[11:0])
      12'h018: return {m_st != S_IDLE, m_st == S_READY, 1'b0, m_avail(), m_expect(), 3'b000};
      12'h019: return b[7:0];
      12'h01A: return b[15:8];
      12'h024: if (m_avail()) begin
        m_rd++;
        return m_rsp[m_rd-1];
      end
      default: ;
    endcase
    return 8'hFF;
  endfunction

  function automatic logic [15:0] adr(input logic [11:0] off);
    return {4'(loc), off};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_wr(input logic [15:0] a, input logic [7:0] d);
    addr_i = a; data_i = d; data_wr_i = 1'b1;
    m_write(a, d);
    cyc();
    data_wr_i = 1'b0;
  endtask

  task automatic do_rd(input logic [15:0] a);
    addr_i = a; data_rd_i = 1'b1;
    rd_exp.push_back(m_read(a));
    cyc();
    data_rd_i = 1'b0;
  endtask

  task automatic do_rdwr(input logic [15:0] a, input logic [7:0] d);
    addr_i = a; data_i = d; data_wr_i = 1'b1; data_rd_i = 1'b1;
    rd_exp.push_back(8'hFF);
    m_write(a, d);
    cyc();
    data_wr_i = 1'b0; data_rd_i = 1'b0;
  endtask

  task automatic chk_sts(input string tag);
    chk({tag, "/command_ready"}, 32'(command_ready_o), 32'(m_st == S_READY));
    chk({tag, "/expect"}, 32'(expect_o), 32'(m_expect()));
    chk({tag, "/data_avail"}, 32'(data_avail_o), 32'(m_avail()));
    chk({tag, "/burst_count"}, 32'(burst_count_o), 32'(m_burst()));
  endtask

  task automatic send_rsp(input logic [7:0] d, input logic done);
    logic r;
    rsp_data_i = d; rsp_valid_i = 1'b1; rsp_done_i = done;
    @(negedge clk);
    r = rsp_ready_o;
    chk("rsp_ready", 32'(r), 32'(m_st == S_EXEC && m_rsp.size() < DEPTH));
    cyc();
    rsp_valid_i = 1'b0; rsp_done_i = 1'b0;
    if (r) m_rsp.push_back(d);
    if (done && m_st == S_EXEC) m_st = S_COMPL;
  endtask

  always @(posedge clk) rd_seen <= data_rd_i;

  always @(negedge clk) begin
    if (!rst_i && (rd_seen || data_valid_o))
      chk("rd_valid_latency", 32'(data_valid_o), 32'(rd_seen));
    if (!rst_i && data_valid_o) begin
      if (rd_exp.size() == 0) chk("rd_unexpected", 32'(1), 32'(0));
      else chk("rd_data", 32'(data_o), 32'(rd_exp.pop_front()));
    end
    if (!rst_i && cmd_valid_o && cmd_ready_i) begin
      if (cmd_exp.size() == 0) chk("cmd_unexpected", 32'(1), 32'(0));
      else chk("cmd_data", 32'(cmd_data_o), 32'(cmd_exp.pop_front()));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] hdr[6];
    addr_i = '0; data_i = '0; data_wr_i = 0; data_rd_i = 0; cmd_ready_i = 0;
    rsp_data_i = '0; rsp_valid_i = 0; rsp_done_i = 0;
    loc = $urandom_range(0, NUM_LOC - 1);
    active_loc_i = 3'(loc);
    m_reset();
    rst_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;
    cyc();
    chk("reset/data_o", 32'(data_o), 32'hFF);
    chk("reset/data_valid", 32'(data_valid_o), 32'(0));
    chk("reset/cmd_valid", 32'(cmd_valid_o), 32'(0));
    chk("reset/cmd_data", 32'(cmd_data_o), 32'(0));
    chk("reset/cmd_go", 32'(cmd_go_o), 32'(0));
    chk("reset/rsp_ready", 32'(rsp_ready_o), 32'(0));
    chk_sts("reset");
    do_rd(adr(12'h018));
    cyc();

    do_wr(adr(12'h018), 8'h40);
    chk_sts("ready");
    hdr[0] = 8'h80; hdr[1] = 8'h01; hdr[2] = 8'h00; hdr[3] = 8'h00; hdr[4] = 8'h00; hdr[5] = 8'h0A;
    for (int i = 0; i < 10; i++) begin
      do_wr(adr(12'h024), (i < 6) ? hdr[i] : 8'($urandom));
      chk_sts($sformatf("rx%0d", i));
    end
    do_wr(adr(12'h018), 8'h20);
    chk("go_pulse", 32'(cmd_go_o), 32'(m_go));
    cyc();
    chk("go_single", 32'(cmd_go_o), 32'(0));
    for (int i = 0; i < 60 && cmd_exp.size() > 0; i++) begin
      cmd_ready_i = (i % 2 == 0);
      cyc();
    end
    cmd_ready_i = 1'b0;
    chk("cmd_drained", 32'(cmd_exp.size()), 32'(0));
    chk("cmd_valid_end", 32'(cmd_valid_o), 32'(0));

    for (int i = 0; i < 12; i++) send_rsp(8'($urandom), i == 11);
    chk_sts("completion");
    for (int i = 0; i < 5; i++) do_rd(adr(12'h024));
    chk_sts("after5");
    do_wr(adr(12'h018), 8'h02);
    chk_sts("retry");
    do_rd(adr(12'h019));
    do_rd(adr(12'h01A));
    for (int i = 0; i < 13; i++) begin
      do_rd(adr(12'h024));
      repeat ($urandom_range(0, 2)) cyc();
    end
    chk_sts("drained");
    do_rd(adr(12'h030));

    do_wr(adr(12'h018), 8'h40);
    do_wr({4'(loc ^ 1), 12'h024}, 8'($urandom));
    chk_sts("loc_mismatch_wr");
    do_rd({4'(loc ^ 1), 12'h018});
    active_loc_i = 3'h7;
    do_wr({4'h7, 12'h024}, 8'($urandom));
    do_rd({4'h7, 12'h018});
    active_loc_i = 3'h5;
    do_wr({4'h5, 12'h024}, 8'($urandom));
    active_loc_i = 3'(loc);
    chk_sts("no_loc_wr");

    do_rdwr(adr(12'h024), 8'h80);
    hdr[1] = 8'h01; hdr[4] = 8'h01; hdr[5] = 8'h00;
    for (int i = 1; i < 65; i++) begin
      do_wr(adr(12'h024), (i < 6) ? hdr[i] : 8'($urandom));
      if (i == 20) begin
        do_wr(adr(12'h018), 8'h20);
        chk("go_ignored", 32'(cmd_go_o), 32'(0));
        active_loc_i = 3'h7;
        do_wr({4'h7, 12'h018}, 8'h40);
        active_loc_i = 3'(loc);
        chk_sts("loc7_sts_ignored");
      end
      if (i >= 63) chk_sts($sformatf("ovf%0d", i));
    end
    do_wr(adr(12'h018), 8'h20);
    chk("go_pulse2", 32'(cmd_go_o), 32'(m_go));
    do_wr(adr(12'h018), 8'h40);
    chk("exec_cr_ignored", 32'(command_ready_o), 32'(0));
    chk("exec_cmd_valid", 32'(cmd_valid_o), 32'(1));

    rst_i = 1'b1;
    #1;
    m_reset();
    cmd_exp.delete();
    chk("midrst/cmd_valid", 32'(cmd_valid_o), 32'(0));
    chk("midrst/cmd_go", 32'(cmd_go_o), 32'(0));
    chk("midrst/data_o", 32'(data_o), 32'hFF);
    chk_sts("midrst");
    cyc();
    rst_i = 1'b0;
    cyc();
    chk_sts("post_rst");
    do_rd(adr(12'h018));
    repeat (3) cyc();
    chk("rd_queue_empty", 32'(rd_exp.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
